// File: rtl/tstate_sequencer_if.sv
// Handshake bundle for the T-state sequencer: opcode/step controls in,
// state decode and retirement status out.
interface tstate_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       ir_op;
  logic             step_en;
  logic             step_req;
  logic [5:0]       tstate;
  logic [2:0]       state_idx;
  logic             fetch;
  logic             instr_done;
  logic             halted;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output ir_op, step_en, step_req,
    input  tstate, state_idx, fetch,
    input  instr_done, halted,
    input  illegal_op, instr_count
  );

  modport slave (
    input  ir_op, step_en, step_req,
    output tstate, state_idx, fetch,
    output instr_done, halted,
    output illegal_op, instr_count
  );
endinterface

// File: rtl/tstate_sequencer.sv
// T1..T6 machine-cycle sequencer with single-step, HALT and retire count.
// SEQ_EARLY_TERM_EN: per-opcode instruction length (else 6 states).
module tstate_sequencer #(
  parameter int CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  tstate_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_q, ill_d;
  logic             step_q;
  logic             rise, adv;
  logic             is_lda, is_add, is_sub;
  logic             is_out, is_hlt, legal;
  logic             last;

  assign is_lda = bus.ir_op == 4'b0000;
  assign is_add = bus.ir_op == 4'b0001;
  assign is_sub = bus.ir_op == 4'b0010;
  assign is_out = bus.ir_op == 4'b1110;
  assign is_hlt = bus.ir_op == 4'b1111;
  assign legal  = is_lda | is_add | is_sub
                | is_out | is_hlt;

  // A rise seen in free-run is consumed here, never banked.
  assign rise = bus.step_req & ~step_q;
  assign adv  = ~bus.step_en | rise;

  always_comb begin
    last = 1'b0;
    case (state_q)
`ifdef SEQ_EARLY_TERM_EN
      S_T4:    last = ~(is_lda | is_add | is_sub);
      S_T5:    last = is_lda;
`else
      S_T4:    last = is_hlt;
`endif
      S_T6:    last = 1'b1;
      default: last = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ill_d   = ill_q;
    if (state_q == S_T4 && !legal)
      ill_d = 1'b1;
    if (state_q != S_HALT && adv) begin
      if (last) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (state_q == S_T4 && is_hlt)
                ? S_HALT : S_T1;
      end else begin
        state_d = state_t'(state_q + 3'd1);
      end
    end
  end

  always_ff @(negedge clk) begin
    if (!rst) begin
      state_q <= S_T1;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      step_q  <= bus.step_req;
    end
  end

  always_comb begin
    bus.tstate = 6'b000000;
    unique case (state_q)
      S_T1:    bus.tstate = 6'b000001;
      S_T2:    bus.tstate = 6'b000010;
      S_T3:    bus.tstate = 6'b000100;
      S_T4:    bus.tstate = 6'b001000;
      S_T5:    bus.tstate = 6'b010000;
      S_T6:    bus.tstate = 6'b100000;
      default: bus.tstate = 6'b000000;
    endcase
  end

  assign bus.state_idx   = state_q;
  assign bus.fetch       = state_q == S_T1
                         | state_q == S_T2
                         | state_q == S_T3;
  assign bus.instr_done  = last;
  assign bus.halted      = state_q == S_HALT;
  assign bus.illegal_op  = ill_q
                         | (state_q == S_T4 & ~legal);
  assign bus.instr_count = cnt_q;

endmodule
